// File: rtl/voltmeter_pkg.sv
// Shared constants, state encoding and helpers for the PmodAD2 voltmeter path.
package voltmeter_pkg;

  localparam int unsigned NUM_CH_DEF   = 4;
  localparam int unsigned ADC_BITS_DEF = 12;
  localparam int unsigned AVG_LOG2_DEF = 3;
  localparam int unsigned DISCARD_DEF  = 1;
  localparam int unsigned VREF_MV_DEF  = 3300;
  localparam int unsigned MV_BITS      = 12;
  localparam int unsigned CH_W         = 2;
  localparam int unsigned MAX_CH       = 4;

  localparam logic [7:0] CFG_CH0 = 8'h10;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CONFIG  = 3'd1;
  localparam logic [2:0] ST_DISCARD = 3'd2;
  localparam logic [2:0] ST_ACCUM   = 3'd3;
  localparam logic [2:0] ST_SCALE   = 3'd4;
  localparam logic [2:0] ST_STORE   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_CONFIG  = ST_CONFIG,
    S_DISCARD = ST_DISCARD,
    S_ACCUM   = ST_ACCUM,
    S_SCALE   = ST_SCALE,
    S_STORE   = ST_STORE
  } scan_state_e;

  // Config byte selecting channel ch: one-hot in bits [7:4].
  function automatic logic [7:0] cfg_byte(input logic [CH_W-1:0] ch);
    return CFG_CH0 << ch;
  endfunction

endpackage

// File: rtl/mv_scaler.sv
// Converts an averaged raw ADC code to millivolts: (avg * VREF_MV) >> ADC_BITS, one cycle latency.
module mv_scaler
  import voltmeter_pkg::*;
#(
  parameter int unsigned ADC_BITS = ADC_BITS_DEF,
  parameter int unsigned VREF_MV  = VREF_MV_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADC_BITS-1:0] avg,
  output logic [MV_BITS-1:0]  mv
);

  localparam int unsigned PROD_W = 2 * ADC_BITS;

  logic [PROD_W-1:0] prod_c;

  assign prod_c = PROD_W'(avg) * PROD_W'(VREF_MV);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mv <= '0;
    end else begin
      mv <= MV_BITS'(prod_c >> ADC_BITS);
    end
  end

endmodule

// File: rtl/adc_channel_scanner.sv
// Automatic PmodAD2 channel sequencer: configures each channel, drops settling samples,
// averages a block of conversions, scales to mV and holds one result per channel.
module adc_channel_scanner
  import voltmeter_pkg::*;
#(
  parameter int unsigned NUM_CH   = NUM_CH_DEF,
  parameter int unsigned ADC_BITS = ADC_BITS_DEF,
  parameter int unsigned AVG_LOG2 = AVG_LOG2_DEF,
  parameter int unsigned DISCARD  = DISCARD_DEF,
  parameter int unsigned VREF_MV  = VREF_MV_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                sample_valid,
  input  logic [ADC_BITS-1:0] sample_data,
  output logic [7:0]          cfg_addr,
  output logic                cfg_update,
  input  logic [CH_W-1:0]     disp_sel,
  output logic [MV_BITS-1:0]  disp_mv,
  output logic                disp_valid,
  output logic                scan_done
);

  localparam int unsigned ACC_W  = ADC_BITS + AVG_LOG2;
  localparam int unsigned CNT_W  = (AVG_LOG2 > 3) ? AVG_LOG2 : 3;
  localparam int unsigned N_SAMP = 1 << AVG_LOG2;

  scan_state_e        state, state_nxt;
  logic [CH_W-1:0]    ch, ch_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic [7:0]         cfg_addr_nxt;
  logic               cfg_update_nxt;
  logic               scan_done_nxt;
  logic [MV_BITS-1:0] result     [MAX_CH];
  logic [MV_BITS-1:0] result_nxt [MAX_CH];
  logic [MAX_CH-1:0]  valid, valid_nxt;
  logic [ADC_BITS-1:0] avg_c;
  logic [MV_BITS-1:0] scaled_mv;

  assign avg_c = ADC_BITS'(acc >> AVG_LOG2);

  mv_scaler #(
    .ADC_BITS (ADC_BITS),
    .VREF_MV  (VREF_MV)
  ) u_scaler (
    .clk (clk),
    .rst (rst),
    .avg (avg_c),
    .mv  (scaled_mv)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      ch         <= '0;
      cnt        <= '0;
      acc        <= '0;
      cfg_addr   <= CFG_CH0;
      cfg_update <= 1'b0;
      scan_done  <= 1'b0;
      valid      <= '0;
      result     <= '{default: '0};
    end else begin
      state      <= state_nxt;
      ch         <= ch_nxt;
      cnt        <= cnt_nxt;
      acc        <= acc_nxt;
      cfg_addr   <= cfg_addr_nxt;
      cfg_update <= cfg_update_nxt;
      scan_done  <= scan_done_nxt;
      valid      <= valid_nxt;
      result     <= result_nxt;
    end
  end

  // Next-state and register updates; dropping enable abandons the current block.
  always_comb begin
    state_nxt      = state;
    ch_nxt         = ch;
    cnt_nxt        = cnt;
    acc_nxt        = acc;
    cfg_addr_nxt   = cfg_addr;
    cfg_update_nxt = 1'b0;
    scan_done_nxt  = 1'b0;
    valid_nxt      = valid;
    result_nxt     = result;

    if (!enable) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      acc_nxt   = '0;
    end else begin
      unique case (state)
        S_IDLE: state_nxt = S_CONFIG;
        S_CONFIG: begin
          cfg_addr_nxt   = cfg_byte(ch);
          cfg_update_nxt = 1'b1;
          cnt_nxt        = '0;
          acc_nxt        = '0;
          state_nxt      = (DISCARD > 0) ? S_DISCARD : S_ACCUM;
        end
        S_DISCARD: begin
          if (sample_valid) begin
            if (cnt == CNT_W'(DISCARD - 1)) begin
              cnt_nxt   = '0;
              state_nxt = S_ACCUM;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
        end
        S_ACCUM: begin
          if (sample_valid) begin
            acc_nxt = acc + ACC_W'(sample_data);
            if (cnt == CNT_W'(N_SAMP - 1)) begin
              cnt_nxt   = '0;
              state_nxt = S_SCALE;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
        end
        S_SCALE: state_nxt = S_STORE;
        S_STORE: begin
          result_nxt[ch] = scaled_mv;
          valid_nxt[ch]  = 1'b1;
          if (ch == CH_W'(NUM_CH - 1)) begin
            ch_nxt        = '0;
            scan_done_nxt = 1'b1;
          end else begin
            ch_nxt = ch + CH_W'(1);
          end
          state_nxt = S_CONFIG;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Display read port; unused channel slots stay zero and invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_mv    <= '0;
      disp_valid <= 1'b0;
    end else begin
      disp_mv    <= result[disp_sel];
      disp_valid <= valid[disp_sel];
    end
  end

endmodule

// File: tb/tb_adc_channel_scanner.sv
// Self-checking bench for adc_channel_scanner: strobe-counting reference model keyed on cfg_update.
module tb_adc_channel_scanner;

  localparam int DISCARD = 1;
  localparam int NSAMP   = 8;
  localparam int VREF    = 3300;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] sample_data = '0;
  logic [7:0]  cfg_addr;
  logic        cfg_update;
  logic [1:0]  disp_sel = '0;
  logic [11:0] disp_mv;
  logic        disp_valid;
  logic        scan_done;

  always #5 clk = ~clk;

  adc_channel_scanner dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .cfg_addr     (cfg_addr),
    .cfg_update   (cfg_update),
    .disp_sel     (disp_sel),
    .disp_mv      (disp_mv),
    .disp_valid   (disp_valid),
    .scan_done    (scan_done)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic en_req = 1'b0;

  // Reference model state
  bit   m_active = 0;
  int   m_ch = 0, m_drop = 0, m_take = 0, m_sum = 0;
  int   exp_mv [4];
  bit   exp_vld [4];
  int   stores = 0, last_store_cyc = 0, last_store_ch = 0;
  int   cfg_seen = 0, done_seen = 0, last_done_cyc = 0;
  logic [7:0] last_cfg = '0;
  logic [7:0] cfg_log [$];

  function automatic int to_mv(input int sum);
    return ((sum / NSAMP) * VREF) / 4096;
  endfunction

  function automatic int ch_of(input logic [7:0] a);
    case (a)
      8'h10: return 0;
      8'h20: return 1;
      8'h40: return 2;
      8'h80: return 3;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_active = 0;
    m_ch = 0;
    for (int i = 0; i < 4; i++) begin
      exp_mv[i] = 0;
      exp_vld[i] = 0;
    end
  endtask

  // One clock: drive inputs after the edge, observe outputs on the falling edge, update the model.
  task automatic step(input bit v, input logic [11:0] d);
    @(posedge clk);
    #1;
    enable = en_req;
    sample_valid = v;
    sample_data = d;
    @(negedge clk);
    cyc++;
    if (cfg_update) begin
      cfg_seen++;
      last_cfg = cfg_addr;
      cfg_log.push_back(cfg_addr);
      m_active = 1;
      m_ch = ch_of(cfg_addr);
      m_drop = DISCARD;
      m_take = NSAMP;
      m_sum = 0;
    end
    if (!enable) m_active = 0;
    if (m_active && v) begin
      if (m_drop > 0) begin
        m_drop--;
      end else begin
        m_sum += int'(d);
        m_take--;
        if (m_take == 0) begin
          m_active = 0;
          exp_mv[m_ch] = to_mv(m_sum);
          exp_vld[m_ch] = 1;
          stores++;
          last_store_cyc = cyc;
          last_store_ch = m_ch;
        end
      end
    end
    if (scan_done) begin
      done_seen++;
      last_done_cyc = cyc;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en_req = 1'b0;
    model_reset();
    repeat (3) step(1'b0, 12'd0);
    n_vec++; if (cfg_addr !== 8'h10) begin n_err++; $display("FAIL reset_cfg_addr got %h want 10", cfg_addr); end
    n_vec++; if (cfg_update !== 1'b0) begin n_err++; $display("FAIL reset_cfg_update got %b want 0", cfg_update); end
    n_vec++; if (disp_mv !== 12'd0) begin n_err++; $display("FAIL reset_disp_mv got %0d want 0", disp_mv); end
    n_vec++; if (disp_valid !== 1'b0) begin n_err++; $display("FAIL reset_disp_valid got %b want 0", disp_valid); end
    n_vec++; if (scan_done !== 1'b0) begin n_err++; $display("FAIL reset_scan_done got %b want 0", scan_done); end
    rst = 1'b1;
  endtask

  task automatic test_full_scale();
    int d0;
    logic [7:0] want;
    en_req = 1'b1;
    cfg_log.delete();
    d0 = done_seen;
    for (int i = 0; i < 3000 && done_seen == d0; i++) step((i % 20) == 0, 12'hFFF);
    n_vec++; if (done_seen == d0) begin n_err++; $display("FAIL fullscale_timeout got no scan_done want one"); end
    for (int k = 0; k < 4; k++) begin
      want = 8'h10 << k;
      n_vec++;
      if (cfg_log.size() <= k || cfg_log[k] !== want) begin
        n_err++;
        $display("FAIL fullscale_cfg_addr[%0d] got %h want %h", k, (cfg_log.size() > k) ? cfg_log[k] : 8'hxx, want);
      end
    end
    for (int i = 0; i < 200; i++) step((i % 20) == 0, 12'hFFF);
    n_vec++; if (done_seen != d0 + 1) begin n_err++; $display("FAIL fullscale_done_count got %0d want %0d", done_seen - d0, 1); end
    for (int k = 0; k < 4; k++) begin
      disp_sel = 2'(k);
      step(1'b0, 12'd0);
      n_vec++; if (disp_mv !== 12'd3299) begin n_err++; $display("FAIL fullscale_mv[%0d] got %0d want 3299", k, disp_mv); end
      n_vec++; if (disp_valid !== 1'b1) begin n_err++; $display("FAIL fullscale_valid[%0d] got %b want 1", k, disp_valid); end
    end
  endtask

  task automatic test_channel_values();
    int vals [4] = '{0, 2048, 1241, 4095};
    int want [4] = '{0, 1650, 999, 3299};
    int d0;
    rst = 1'b0;
    model_reset();
    step(1'b0, 12'd0);
    rst = 1'b1;
    d0 = done_seen;
    for (int i = 0; i < 3000 && done_seen == d0; i++)
      step($urandom_range(0, 2) == 0, 12'(vals[m_ch]));
    n_vec++; if (done_seen == d0) begin n_err++; $display("FAIL chvals_timeout got no scan_done want one"); end
    for (int k = 0; k < 4; k++) begin
      disp_sel = 2'(k);
      step(1'b0, 12'd0);
      n_vec++; if (disp_mv !== 12'(want[k])) begin n_err++; $display("FAIL chvals_mv[%0d] got %0d want %0d", k, disp_mv, want[k]); end
      n_vec++; if (disp_valid !== 1'b1) begin n_err++; $display("FAIL chvals_valid[%0d] got %b want 1", k, disp_valid); end
    end
  endtask

  task automatic test_average();
    int d0;
    bit alt = 0;
    bit v;
    logic [11:0] d;
    d0 = done_seen;
    for (int i = 0; i < 3000 && done_seen == d0; i++) begin
      v = m_active && ((i % 3) == 0);
      d = 12'd0;
      if (v) begin
        if (m_drop > 0) d = 12'd4095;
        else begin
          d = alt ? 12'd1003 : 12'd1000;
          alt = !alt;
        end
      end
      step(v, d);
    end
    n_vec++; if (done_seen == d0) begin n_err++; $display("FAIL average_timeout got no scan_done want one"); end
    for (int k = 0; k < 4; k++) begin
      disp_sel = 2'(k);
      step(1'b0, 12'd0);
      n_vec++; if (disp_mv !== 12'd806) begin n_err++; $display("FAIL average_mv[%0d] got %0d want 806", k, disp_mv); end
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_seen;
    disp_sel = 2'd3;
    for (int i = 0; i < 300 && done_seen == d0; i++) step(1'b1, 12'($urandom));
    n_vec++; if (done_seen == d0) begin n_err++; $display("FAIL b2b_timeout got no scan_done want one"); end
    n_vec++;
    if (last_store_ch != 3 || last_done_cyc - last_store_cyc != 3) begin
      n_err++;
      $display("FAIL b2b_done_latency got ch%0d +%0d want ch3 +3", last_store_ch, last_done_cyc - last_store_cyc);
    end
    step(1'b1, 12'($urandom));
    n_vec++; if (disp_mv !== 12'(exp_mv[3])) begin n_err++; $display("FAIL b2b_disp_latency got %0d want %0d", disp_mv, exp_mv[3]); end
    for (int k = 0; k < 4; k++) begin
      disp_sel = 2'(k);
      step(1'b0, 12'd0);
      n_vec++; if (disp_mv !== 12'(exp_mv[k])) begin n_err++; $display("FAIL b2b_mv[%0d] got %0d want %0d", k, disp_mv, exp_mv[k]); end
    end
  endtask

  task automatic test_random_scan();
    int d0;
    d0 = done_seen;
    for (int i = 0; i < 3000 && done_seen < d0 + 2; i++)
      step($urandom_range(0, 1) == 1, 12'($urandom));
    n_vec++; if (done_seen < d0 + 2) begin n_err++; $display("FAIL random_timeout got %0d scans want 2", done_seen - d0); end
    for (int k = 0; k < 4; k++) begin
      disp_sel = 2'(k);
      step(1'b0, 12'd0);
      n_vec++; if (disp_mv !== 12'(exp_mv[k])) begin n_err++; $display("FAIL random_mv[%0d] got %0d want %0d", k, disp_mv, exp_mv[k]); end
      n_vec++; if (disp_valid !== exp_vld[k]) begin n_err++; $display("FAIL random_valid[%0d] got %b want %b", k, disp_valid, exp_vld[k]); end
    end
  endtask

  task automatic test_enable_drop();
    int c0, d0, s0;
    bit hit = 0;
    rst = 1'b0;
    model_reset();
    step(1'b0, 12'd0);
    rst = 1'b1;
    for (int i = 0; i < 2000 && !hit; i++) begin
      step((i % 2) == 0, 12'hFFF);
      hit = m_active && m_ch == 2 && m_drop == 0 && m_take == 5;
    end
    n_vec++; if (!hit) begin n_err++; $display("FAIL endrop_reach_ch2 got no ch2 accumulation want one"); end
    en_req = 1'b0;
    c0 = cfg_seen;
    d0 = done_seen;
    repeat (12) step(1'b1, 12'hFFF);
    n_vec++; if (cfg_seen != c0) begin n_err++; $display("FAIL endrop_idle_cfg got %0d updates want 0", cfg_seen - c0); end
    n_vec++; if (done_seen != d0) begin n_err++; $display("FAIL endrop_idle_done got %0d pulses want 0", done_seen - d0); end
    for (int k = 0; k < 3; k++) begin
      disp_sel = 2'(k);
      step(1'b0, 12'd0);
      n_vec++; if (disp_valid !== (k < 2)) begin n_err++; $display("FAIL endrop_valid[%0d] got %b want %b", k, disp_valid, k < 2); end
      if (k < 2) begin
        n_vec++; if (disp_mv !== 12'd3299) begin n_err++; $display("FAIL endrop_keep_mv[%0d] got %0d want 3299", k, disp_mv); end
      end
    end
    en_req = 1'b1;
    for (int i = 0; i < 10 && cfg_seen == c0; i++) step(1'b0, 12'd0);
    n_vec++; if (last_cfg !== 8'h40 || cfg_seen == c0) begin n_err++; $display("FAIL endrop_resume_cfg got %h want 40", last_cfg); end
    s0 = stores;
    for (int i = 0; i < 500 && stores == s0; i++) step((i % 2) == 0, 12'd100);
    repeat (3) step(1'b0, 12'd0);
    disp_sel = 2'd2;
    step(1'b0, 12'd0);
    n_vec++; if (disp_mv !== 12'd80) begin n_err++; $display("FAIL endrop_ch2_mv got %0d want 80", disp_mv); end
    n_vec++; if (disp_valid !== 1'b1) begin n_err++; $display("FAIL endrop_ch2_valid got %b want 1", disp_valid); end
  endtask

  task automatic test_reset_mid_scale();
    int s0, c0;
    disp_sel = 2'd0;
    s0 = stores;
    for (int i = 0; i < 500 && stores == s0; i++) step((i % 2) == 0, 12'($urandom));
    n_vec++; if (disp_valid !== 1'b1) begin n_err++; $display("FAIL midscale_pre_valid got %b want 1", disp_valid); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_vec++; if (cfg_addr !== 8'h10) begin n_err++; $display("FAIL midscale_cfg_addr got %h want 10", cfg_addr); end
    n_vec++; if (cfg_update !== 1'b0) begin n_err++; $display("FAIL midscale_cfg_update got %b want 0", cfg_update); end
    n_vec++; if (disp_mv !== 12'd0) begin n_err++; $display("FAIL midscale_disp_mv got %0d want 0", disp_mv); end
    n_vec++; if (disp_valid !== 1'b0) begin n_err++; $display("FAIL midscale_disp_valid got %b want 0", disp_valid); end
    n_vec++; if (scan_done !== 1'b0) begin n_err++; $display("FAIL midscale_scan_done got %b want 0", scan_done); end
    model_reset();
    step(1'b0, 12'd0);
    rst = 1'b1;
    c0 = cfg_seen;
    for (int k = 0; k < 4; k++) begin
      disp_sel = 2'(k);
      step(1'b0, 12'd0);
      n_vec++; if (disp_valid !== 1'b0) begin n_err++; $display("FAIL midscale_post_valid[%0d] got %b want 0", k, disp_valid); end
    end
    for (int i = 0; i < 10 && cfg_seen == c0; i++) step(1'b0, 12'd0);
    n_vec++; if (last_cfg !== 8'h10 || cfg_seen == c0) begin n_err++; $display("FAIL midscale_restart_cfg got %h want 10", last_cfg); end
    s0 = stores;
    for (int i = 0; i < 500 && stores == s0; i++) step((i % 2) == 0, 12'($urandom));
    repeat (3) step(1'b0, 12'd0);
    disp_sel = 2'd0;
    step(1'b0, 12'd0);
    n_vec++; if (disp_valid !== 1'b1 || disp_mv !== 12'(exp_mv[0])) begin n_err++; $display("FAIL midscale_ch0 got %b/%0d want 1/%0d", disp_valid, disp_mv, exp_mv[0]); end
    disp_sel = 2'd1;
    step(1'b0, 12'd0);
    n_vec++; if (disp_valid !== 1'b0) begin n_err++; $display("FAIL midscale_ch1_valid got %b want 0", disp_valid); end
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_channel_values();
    test_average();
    test_back_to_back();
    test_random_scan();
    test_enable_drop();
    test_reset_mid_scale();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
